// File: rtl/free_list_nway.sv
// N-wide physical-register free list for the rename stage: circular buffer of free PR tags with
// multi-lane allocate, multi-lane free and checkpointed head rollback.
module free_list_nway #(
   parameter int unsigned NUM_PR     = 64,
   parameter int unsigned NUM_ARCH   = 32,
   parameter int unsigned DISPATCH_W = 2,
   parameter int unsigned RETIRE_W   = 2,
   parameter int unsigned ZERO_ARCH  = 31,
   parameter int unsigned ZERO_PR    = 31,
   localparam int unsigned PR_W      = $clog2(NUM_PR),
   localparam int unsigned NUM_FL    = NUM_PR - NUM_ARCH,
   localparam int unsigned IDX_W     = $clog2(NUM_FL),
   localparam int unsigned PTR_W     = IDX_W + 1,
   localparam int unsigned CNT_W     = $clog2(NUM_FL + 1)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [DISPATCH_W-1:0]            dispatch_valid,
   input  logic [DISPATCH_W-1:0][4:0]       dest_idx,
   output logic                             dispatch_ack,
   output logic [DISPATCH_W-1:0][PR_W-1:0]  T_idx,
   output logic [PTR_W-1:0]                 FL_idx,
   output logic                             FL_ready,
   output logic [CNT_W-1:0]                 free_cnt,
   input  logic [RETIRE_W-1:0]              retire_valid,
   input  logic [RETIRE_W-1:0][PR_W-1:0]    T_old_idx,
   input  logic                             rollback_en,
   input  logic [PTR_W-1:0]                 FL_rollback_idx
);

   if ((NUM_FL & (NUM_FL - 1)) != 0) begin : g_bad_num_fl
      $error("free_list_nway: NUM_PR-NUM_ARCH must be a power of two");
   end

   logic [PR_W-1:0]  fl_table_q [NUM_FL];
   logic [PR_W-1:0]  fl_table_d [NUM_FL];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
   logic             fl_ready_q, fl_ready_d;

   logic [CNT_W-1:0] need_cnt, pop_cnt, push_cnt;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;

   // Needing lanes read consecutive entries from head; the group commits only if it all fits.
   always_comb begin
      need_cnt = '0;
      rd_ptr   = head_q;
      for (int i = 0; i < DISPATCH_W; i++) begin
         T_idx[i] = PR_W'(ZERO_PR);
         if (dispatch_valid[i] && (dest_idx[i] != 5'(ZERO_ARCH))) begin
            T_idx[i] = fl_table_q[rd_ptr[IDX_W-1:0]];
            rd_ptr   = rd_ptr + PTR_W'(1);
            need_cnt = need_cnt + CNT_W'(1);
         end
      end
      dispatch_ack = !rollback_en && (need_cnt <= free_cnt_q);
      pop_cnt      = dispatch_ack ? need_cnt : '0;
   end

   always_comb begin
      fl_table_d = fl_table_q;
      wr_ptr     = tail_q;
      push_cnt   = '0;
      for (int j = 0; j < RETIRE_W; j++) begin
         if (retire_valid[j] && (T_old_idx[j] != PR_W'(ZERO_PR))) begin
            fl_table_d[wr_ptr[IDX_W-1:0]] = T_old_idx[j];
            wr_ptr   = wr_ptr + PTR_W'(1);
            push_cnt = push_cnt + CNT_W'(1);
         end
      end
      tail_d = wr_ptr;
   end

   // On rollback the count is rebuilt from the pointers; modular PTR_W math yields NUM_FL when full.
   always_comb begin
      if (rollback_en) begin
         head_d     = FL_rollback_idx;
         free_cnt_d = CNT_W'(tail_d - FL_rollback_idx);
      end else begin
         head_d     = head_q + PTR_W'(pop_cnt);
         free_cnt_d = free_cnt_q - pop_cnt + push_cnt;
      end
      fl_ready_d = (free_cnt_d >= CNT_W'(DISPATCH_W));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_FL; i++) begin
            fl_table_q[i] <= PR_W'(NUM_ARCH + i);
         end
         head_q     <= '0;
         tail_q     <= PTR_W'(NUM_FL);
         free_cnt_q <= CNT_W'(NUM_FL);
         fl_ready_q <= 1'b1;
      end else begin
         fl_table_q <= fl_table_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         free_cnt_q <= free_cnt_d;
         fl_ready_q <= fl_ready_d;
      end
   end

   assign FL_idx   = head_d;
   assign FL_ready = fl_ready_q;
   assign free_cnt = free_cnt_q;

   a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
      push_cnt <= (CNT_W'(NUM_FL) - free_cnt_q))
      else $error("free_list_nway: retire pushed more tags than free slots");

endmodule

// File: tb/tb_free_list_nway.sv
// Directed bench for free_list_nway: the driver queues expected outputs per cycle and an
// independent negedge monitor pops and compares them.
module tb_free_list_nway;

   logic             clock;
   logic             reset;
   logic [1:0]       dispatch_valid;
   logic [1:0][4:0]  dest_idx;
   logic             dispatch_ack;
   logic [1:0][5:0]  T_idx;
   logic [5:0]       FL_idx;
   logic             FL_ready;
   logic [5:0]       free_cnt;
   logic [1:0]       retire_valid;
   logic [1:0][5:0]  T_old_idx;
   logic             rollback_en;
   logic [5:0]       FL_rollback_idx;

   free_list_nway dut (
      .clock           (clock),
      .reset           (reset),
      .dispatch_valid  (dispatch_valid),
      .dest_idx        (dest_idx),
      .dispatch_ack    (dispatch_ack),
      .T_idx           (T_idx),
      .FL_idx          (FL_idx),
      .FL_ready        (FL_ready),
      .free_cnt        (free_cnt),
      .retire_valid    (retire_valid),
      .T_old_idx       (T_old_idx),
      .rollback_en     (rollback_en),
      .FL_rollback_idx (FL_rollback_idx)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // -1 in any field means "not checked this cycle".
   typedef struct {
      string nm;
      int    ack;
      int    t0;
      int    t1;
      int    fi;
      int    cnt;
      int    rdy;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input string fld, input int act, input int want);
      if (want >= 0) begin
         total++;
         if (act != want) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, want);
         end
      end
   endtask

   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.nm, "ack",      int'(dispatch_ack), mon_e.ack);
         chk(mon_e.nm, "T_idx0",   int'(T_idx[0]),     mon_e.t0);
         chk(mon_e.nm, "T_idx1",   int'(T_idx[1]),     mon_e.t1);
         chk(mon_e.nm, "FL_idx",   int'(FL_idx),       mon_e.fi);
         chk(mon_e.nm, "free_cnt", int'(free_cnt),     mon_e.cnt);
         chk(mon_e.nm, "FL_ready", int'(FL_ready),     mon_e.rdy);
      end
   end

   task automatic drv(input logic [1:0] dv, input int d0, input int d1,
                      input logic [1:0] rv, input int o0, input int o1,
                      input logic rb, input int rbi);
      dispatch_valid  = dv;
      dest_idx[0]     = 5'(d0);
      dest_idx[1]     = 5'(d1);
      retire_valid    = rv;
      T_old_idx[0]    = 6'(o0);
      T_old_idx[1]    = 6'(o1);
      rollback_en     = rb;
      FL_rollback_idx = 6'(rbi);
   endtask

   task automatic exp_push(input string nm, input int ack, input int t0, input int t1,
                           input int fi, input int cnt, input int rdy);
      exp_t e;
      e.nm  = nm;
      e.ack = ack;
      e.t0  = t0;
      e.t1  = t1;
      e.fi  = fi;
      e.cnt = cnt;
      e.rdy = rdy;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;

      // Reset state, then the first two-lane allocation.
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("rst", 1, 31, 31, 0, 32, 1);
      tick();
      drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
      exp_push("alloc2", 1, 32, 33, 2, 32, 1);
      tick();
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("alloc2_next", 1, 31, 31, 2, 30, 1);
      tick();

      // Zero-register lane consumes nothing.
      drv(2'b11, 31, 5, 2'b00, 0, 0, 1'b0, 0);
      exp_push("zero_lane", 1, 31, 34, 3, 30, 1);
      tick();
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("zero_lane_next", 1, 31, 31, 3, 29, 1);
      tick();

      // Drain from free_cnt=29 down to 1.
      for (int k = 0; k < 14; k++) begin
         drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
         exp_push("drain", 1, 35 + 2 * k, 36 + 2 * k, 5 + 2 * k, 29 - 2 * k, 1);
         tick();
      end

      drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
      exp_push("no_fit", 0, 63, 32, 31, 1, 0);
      tick();
      drv(2'b01, 7, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("last_one", 1, 63, 31, 32, 1, 0);
      tick();
      drv(2'b01, 3, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("empty", 0, 32, 31, 32, 0, 0);
      tick();

      // Same-cycle free is not bypassed; ZERO_PR retire is dropped.
      drv(2'b01, 4, 0, 2'b11, 40, 31, 1'b0, 0);
      exp_push("no_bypass", 0, 32, 31, 32, 0, 0);
      tick();
      drv(2'b01, 4, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("wrap_alloc", 1, 40, 31, 33, 1, 0);
      tick();

      // Refill 8 tags (41..48) at table indices 1..8.
      for (int m = 0; m < 4; m++) begin
         drv(2'b00, 0, 0, 2'b11, 41 + 2 * m, 42 + 2 * m, 1'b0, 0);
         exp_push("push", 1, 31, 31, 33, 2 * m, (m >= 1) ? 1 : 0);
         tick();
      end
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("ckpt", 1, 31, 31, 33, 8, 1);
      tick();

      for (int n = 0; n < 3; n++) begin
         drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
         exp_push("post_ckpt", 1, 41 + 2 * n, 42 + 2 * n, 35 + 2 * n, 8 - 2 * n, 1);
         tick();
      end

      // Rollback to 33 while retiring tag 50: head=33, tail=42 -> free_cnt=9.
      drv(2'b11, 1, 2, 2'b01, 50, 0, 1'b1, 33);
      exp_push("rollback", 0, 47, 48, 33, 2, 1);
      tick();
      drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
      exp_push("reissue", 1, 41, 42, 35, 9, 1);
      tick();
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("post_rb", 1, 31, 31, 35, 7, 1);
      tick();

      // Asynchronous reset between edges during a dispatch burst.
      drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
      exp_push("mid_rst", 1, 32, 33, 2, 32, 1);
      #2;
      reset = 1'b0;
      tick();
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);
      exp_push("in_rst", 1, 31, 31, 0, 32, 1);
      tick();
      reset = 1'b1;
      drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
      exp_push("after_rst", 1, 32, 33, 2, 32, 1);
      tick();
      // Indices 8 and 9 were overwritten with 48 and 50 before reset; they must read 40, 41 now.
      for (int p = 0; p < 4; p++) begin
         drv(2'b11, 1, 2, 2'b00, 0, 0, 1'b0, 0);
         exp_push("table_rst", 1, 34 + 2 * p, 35 + 2 * p, 4 + 2 * p, 30 - 2 * p, 1);
         tick();
      end
      drv(2'b00, 0, 0, 2'b00, 0, 0, 1'b0, 0);

      repeat (3) @(negedge clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
